// File: rtl/result_serializer_pkg.sv
// result_serializer_pkg: shared widths, MMU phase constants and serializer FSM states.
package result_serializer_pkg;
    localparam int ACC_W_DEF = 16;
    localparam int OUT_W_DEF = 8;
    localparam logic [2:0] PH_C00     = 3'd2;
    localparam logic [2:0] PH_C01_C10 = 3'd3;
    localparam logic [2:0] PH_C11     = 3'd4;
    localparam logic [2:0] PH_XFER    = 3'd5;
    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;
endpackage

// File: rtl/result_serializer_bank.sv
// result_bank: four ACC_W registers, each with its own load enable.
module result_bank #(
    parameter int ACC_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            ld,
    input  logic [3:0][ACC_W-1:0] d,
    output logic [3:0][ACC_W-1:0] q
);
    logic [3:0][ACC_W-1:0] bank_q, bank_d;

    always_comb begin
        bank_d = bank_q;
        for (int i = 0; i < 4; i++) bank_d[i] = ld[i] ? d[i] : bank_q[i];
    end

    always_ff @(posedge clk) begin
        if (rst) bank_q <= '0;
        else     bank_q <= bank_d;
    end

    assign q = bank_q;
endmodule

// File: rtl/result_serializer.sv
// result_serializer: captures the 2x2 MMU result over phases 2-4 and streams it
// out as 8 bytes (hi then lo per element) starting one clock after the phase-5 transfer.
module result_serializer
    import result_serializer_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mmu_en,
    input  logic [2:0]       mmu_cycle,
    input  logic [ACC_W-1:0] c00,
    input  logic [ACC_W-1:0] c01,
    input  logic [ACC_W-1:0] c10,
    input  logic [ACC_W-1:0] c11,
    output logic [OUT_W-1:0] data_out,
    output logic             out_valid,
    output logic             frame_start,
    output logic             state_out
);
    state_t                state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic [3:0]            flags_q, flags_d;
    logic [OUT_W-1:0]      data_out_q, data_out_d;
    logic                  out_valid_q, out_valid_d;
    logic                  frame_start_q, frame_start_d;
    logic [3:0]            cap_ld;
    logic                  xfer, stream;
    logic [ACC_W-1:0]      sel;
    logic [3:0][ACC_W-1:0] cap_q, out_q;

    result_bank #(.ACC_W(ACC_W)) u_cap_bank (
        .clk (clk),
        .rst (rst),
        .ld  (cap_ld),
        .d   ({c11, c10, c01, c00}),
        .q   (cap_q)
    );

    // The output bank only changes on a transfer, so capture of the next frame
    // can proceed while this one streams.
    result_bank #(.ACC_W(ACC_W)) u_out_bank (
        .clk (clk),
        .rst (rst),
        .ld  ({4{xfer}}),
        .d   (cap_q),
        .q   (out_q)
    );

    always_comb begin
        cap_ld[0]     = mmu_en && mmu_cycle == PH_C00;
        cap_ld[1]     = mmu_en && mmu_cycle == PH_C01_C10;
        cap_ld[2]     = mmu_en && mmu_cycle == PH_C01_C10;
        cap_ld[3]     = mmu_en && mmu_cycle == PH_C11;
        xfer          = mmu_en && mmu_cycle == PH_XFER && (&flags_q);
        flags_d       = (mmu_en && mmu_cycle == PH_XFER) ? 4'b0 : (flags_q | cap_ld);
        stream        = state_q == S_STREAM;
        state_d       = xfer ? S_STREAM : (stream && idx_q == 3'd7) ? S_IDLE : state_q;
        idx_d         = xfer ? 3'd0 : (stream && idx_q != 3'd7) ? idx_q + 3'd1 : idx_q;
        sel           = out_q[idx_q[2:1]];
        data_out_d    = !stream ? '0 : idx_q[0] ? sel[OUT_W-1:0] : sel[ACC_W-1:OUT_W];
        out_valid_d   = stream;
        frame_start_d = stream && idx_q == 3'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            flags_q       <= '0;
            data_out_q    <= '0;
            out_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            flags_q       <= flags_d;
            data_out_q    <= data_out_d;
            out_valid_q   <= out_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign data_out    = data_out_q;
    assign out_valid   = out_valid_q;
    assign frame_start = frame_start_q;
    assign state_out   = state_q;
endmodule
